// File: rtl/rf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rf_pkg                                                   |
// | Description : Shared definitions for the scoreboarded register file:   |
// |               default sizes, register-0 address and helpers that       |
// |               locate a port's slice inside a flattened port bus.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package rf_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // Architectural zero register: never stored, never busy.
  localparam int REG0_ADDR = 0;

  // Lowest bit of port 'port' in a bus made of 'width'-bit fields.
  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rf_scoreboard                                            |
// | Description : One busy bit per architectural register. A bit is set   |
// |               when an instruction targeting it issues and cleared when |
// |               its writeback lands. Register 0 never goes busy.         |
// | Ports       : clk, rst    - clock, synchronous active-high reset       |
// |               set_en/addr - issue of a destination register            |
// |               clr_en/addr - writeback of a destination register        |
// |               busy        - registered busy vector, bit 0 always 0     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    // Clear first, then set: when the same register retires and is
    // re-targeted in one cycle, the newer producer must remain pending.
    if (clr_en && (clr_addr != AW'(REG0_ADDR))) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_en && (set_addr != AW'(REG0_ADDR))) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[REG0_ADDR] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : regfile_sb                                               |
// | Description : Integer register file with NREAD combinational read      |
// |               ports, one synchronous write port with optional          |
// |               write-to-read bypass, hard-wired x0 and a per-register   |
// |               busy scoreboard for decode stalls.                       |
// | Ports       : clk, rst          - clock, synchronous active-high reset |
// |               rd_addr/rd_data   - flattened read ports                 |
// |               rd_busy           - busy flag of each addressed register |
// |               WE3, A3, WD3      - writeback port                       |
// |               iss_valid, iss_rd - destination of the issuing instr.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  WE3,
  input  logic [AW-1:0]         A3,
  input  logic [XLEN-1:0]       WD3,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd
);

  // ---------------------------------------------------------------------
  // Data array. Entry 0 is tied to zero every cycle, so it reduces to a
  // constant and reads of x0 fall out of the normal array lookup.
  // ---------------------------------------------------------------------
  logic [NREGS-1:0][XLEN-1:0] mem_q;
  logic [NREGS-1:0][XLEN-1:0] mem_d;
  logic                       wr_active;

  assign wr_active = WE3 && (A3 != AW'(REG0_ADDR));

  always_comb begin
    mem_d = mem_q;
    if (wr_active) begin
      mem_d[A3] = WD3;
    end
    mem_d[REG0_ADDR] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard: issue sets, writeback clears.
  // ---------------------------------------------------------------------
  logic [NREGS-1:0] busy;

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_valid),
    .set_addr (iss_rd),
    .clr_en   (WE3),
    .clr_addr (A3),
    .busy     (busy)
  );

  // ---------------------------------------------------------------------
  // Read ports. A bypass hit forwards the in-flight write data and hides
  // the busy bit, since the consumer already has the value it waits for.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NREAD; i++) begin : g_rd_port
    logic [AW-1:0] port_addr;
    logic          bypass_hit;

    assign port_addr  = rd_addr[slice_lsb(i, AW) +: AW];
    assign bypass_hit = (BYPASS != 0) && wr_active && (A3 == port_addr);

    assign rd_data[slice_lsb(i, XLEN) +: XLEN] = bypass_hit ? WD3 : mem_q[port_addr];
    assign rd_busy[i] = bypass_hit ? 1'b0 : busy[port_addr];
  end

endmodule : regfile_sb
`default_nettype wire
